// File: rtl/cpu_pkg.sv
// Shared fetch/decode definitions: instruction index and word widths and the fetch entry layout.
// Fetch, icache, instr_queue and decode all import this so entry layouts never drift.
package cpu_pkg;

   localparam int INDEX_W = 32;
   localparam int INSTR_W = 16;

   typedef struct packed {
      logic [INDEX_W-1:0] index;
      logic [INSTR_W-1:0] instr;
   } fetch_entry_t;

   function automatic int ptr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/instr_queue_if.sv
// Valid/ready channel carrying one fetch entry; master drives valid/entry, slave drives ready.
// Used for both the fetch-to-queue push side and the queue-to-decode pop side.
interface instr_queue_if;
   import cpu_pkg::*;

   logic         valid;
   logic         ready;
   fetch_entry_t entry;

   modport master (output valid, output entry, input ready);
   modport slave  (input valid, input entry, output ready);

endinterface

// File: rtl/instr_queue_ctrl.sv
// Pointer/occupancy/flush control for instr_queue: push_ready from registered count, flush wins.
// With INSTR_QUEUE_BYPASS_EN an empty queue forwards the incoming entry straight to the head.
module instr_queue_ctrl
   import cpu_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int PW = ptr_w(DEPTH),
   localparam int CW = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push_valid_i,
   input  logic          pop_ready_i,
   input  logic          flush_i,
   output logic          push_ready_o,
   output logic          pop_valid_o,
   output logic          bypass_o,
   output logic          wr_en_o,
   output logic [PW-1:0] wr_ptr_o,
   output logic [PW-1:0] rd_ptr_o,
   output logic [CW-1:0] count_o
);

   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          empty, push_fire, pop_fire, bypass_take, rd_adv;

   assign empty        = (count_q == '0);
   assign push_ready_o = (count_q != FULL);

`ifdef INSTR_QUEUE_BYPASS_EN
   assign bypass_o = empty & push_valid_i & ~flush_i;
`else
   assign bypass_o = 1'b0;
`endif

   assign pop_valid_o = ~empty | bypass_o;
   assign push_fire   = push_valid_i & push_ready_o;
   assign pop_fire    = pop_valid_o & pop_ready_i;
   assign bypass_take = bypass_o & pop_ready_i;
   // A bypassed entry consumed in the same cycle never touches storage.
   assign wr_en_o     = push_fire & ~flush_i & ~bypass_take;
   assign rd_adv      = pop_fire & ~empty & ~flush_i;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (wr_en_o) wr_ptr_d = wr_ptr_q + PW'(1);
         if (rd_adv)  rd_ptr_d = rd_ptr_q + PW'(1);
         case ({wr_en_o, rd_adv})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign wr_ptr_o = wr_ptr_q;
   assign rd_ptr_o = rd_ptr_q;
   assign count_o  = count_q;

endmodule

// File: rtl/instr_queue.sv
// Prefetch instruction FIFO between fetch/icache and decode; head visible 1 cycle after push.
// Backpressures fetch when full; flush empties it. INSTR_QUEUE_BYPASS_EN adds same-cycle bypass.
module instr_queue
   import cpu_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int PW = ptr_w(DEPTH),
   localparam int CW = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   instr_queue_if.slave  push,
   instr_queue_if.master pop,
   input  logic          flush,
   output logic [CW-1:0] count
);

   fetch_entry_t  mem_q [DEPTH];
   logic          wr_en, bypass, pop_valid;
   logic [PW-1:0] wr_ptr, rd_ptr;

   instr_queue_ctrl #(.DEPTH(DEPTH)) u_ctrl (
      .clk          (clk),
      .rst_n        (rst_n),
      .push_valid_i (push.valid),
      .pop_ready_i  (pop.ready),
      .flush_i      (flush),
      .push_ready_o (push.ready),
      .pop_valid_o  (pop_valid),
      .bypass_o     (bypass),
      .wr_en_o      (wr_en),
      .wr_ptr_o     (wr_ptr),
      .rd_ptr_o     (rd_ptr),
      .count_o      (count)
   );

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr] <= push.entry;
   end

   // Gate stale storage so an empty queue always presents zeros.
   assign pop.valid = pop_valid;
   assign pop.entry = bypass    ? push.entry    :
                      pop_valid ? mem_q[rd_ptr] : '0;

endmodule
